// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and end-of-range mode encodings for the Gray counter
// family and its downstream decode stage.
package gray_pkg;

    localparam int MAX_WIDTH     = 16;
    localparam int MODE_SATURATE = 0;
    localparam int MODE_WRAP     = 1;

    // Values narrower than MAX_WIDTH are passed zero-extended; the result is then
    // valid in the low bits because the zero top bits contribute nothing.
    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] gray);
        logic [MAX_WIDTH-1:0] bin;
        bin[MAX_WIDTH-1] = gray[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_counter_bin2gray_comb.sv
// Purely combinational binary-to-Gray conversion, one XOR per bit below the MSB.
module bin2gray_comb #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray[WIDTH-1] = bin[WIDTH-1];

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
            assign gray[gi] = bin[gi] ^ bin[gi+1];
        end
    endgenerate

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with registered Gray-coded output, binary load,
// wrap-or-saturate range ends and a registered terminal-count pulse.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int WRAP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray_out,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;
    logic             tc_q;
    logic             tc_d;
    logic             at_max;
    logic             at_min;
    logic             boundary;

    assign at_max   = (cnt_q == {WIDTH{1'b1}});
    assign at_min   = (cnt_q == '0);
    assign boundary = en && ((up && at_max) || (!up && at_min));

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            if (boundary) begin
                tc_d = 1'b1;
                if (WRAP == MODE_WRAP) begin
                    cnt_d = up ? '0 : {WIDTH{1'b1}};
                end
            end else begin
                cnt_d = up ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
            end
        end
    end

    // Gray is derived from the next count so both registers update on the same edge.
    bin2gray_comb #(
        .WIDTH(WIDTH)
    ) u_bin2gray (
        .bin  (cnt_d),
        .gray (gray_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            gray_q <= '0;
            tc_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
        end
    end

    assign gray_out = gray_q;
    assign tc       = tc_q;

endmodule

// File: doc/gray_counter.md
# gray_counter

Parameterised up/down counter that produces a registered Gray-coded value. It sits directly upstream of the Gray-to-binary stage, and each step changes exactly one bit of `gray_out`, so the value can cross a clock domain safely before decoding. The block also provides a binary load, wrap or saturate at the ends of the range, and a terminal-count pulse.

## Interface
Parameters:
- `WIDTH`, default 4: counter width in bits; legal values 2 to 16.
- `WRAP`, default 1: selects end-of-range behaviour.
  - 1: wrap around (modulo 2^WIDTH).
  - 0: saturate at 0 and at 2^WIDTH-1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `en`  in  1  step enable; one step per cycle while high.
- `up`  in  1  direction: 1 counts up, 0 counts down. Sampled only when `en=1`.
- `load`  in  1  synchronous load of `load_val`.
- `load_val`  in  WIDTH  binary value to load.
- `gray_out`  out  WIDTH  registered Gray code of the internal binary count.
- `tc`  out  1  registered one-cycle terminal-count pulse.

## Operation
- Internal state is a binary count `cnt_q` (WIDTH bits).
- `gray_out` always equals `cnt_q ^ (cnt_q >> 1)`.
  - It is registered in the same edge as `cnt_q`, so the two never disagree.
  - No combinational path from any input to `gray_out`.
- Priority per edge, highest first:
  - `rst`: `cnt_q`=0, `gray_out`=0, `tc`=0.
  - `load`: `cnt_q`=`load_val`; `en` and `up` are ignored that cycle.
  - `en`: step `cnt_q` by +1 (`up`=1) or -1 (`up`=0).
  - Otherwise: hold all state. `tc` returns to 0.
- Boundary step: `en=1`, `load=0`, and either `cnt_q`=2^WIDTH-1 with `up`=1, or `cnt_q`=0 with `up`=0.
  - `WRAP=1`: count wraps (max→0 or 0→max). `tc`=1 for the following cycle.
  - `WRAP=0`: count holds. `tc`=1 for the following cycle, and on every further attempted boundary step.
- `tc`=0 after any non-boundary step, any load (even to 0 or max), any idle cycle, and after reset.
- Direction may reverse on any cycle. The result is still a single-step change.
- Single-bit guarantee:
  - Any step (non-load, non-reset) changes exactly one bit of `gray_out`, or no bits when saturated.
  - Load and reset may change several bits; downstream consumers must treat them as discontinuities.
- All arithmetic is modulo 2^WIDTH on an unsigned WIDTH-bit value. No overflow bit is kept.

## Timing
- Latency: a control input sampled at edge N is visible on `gray_out` and `tc` after edge N.
- Throughput: one step per cycle.
- Reset values: `gray_out`=0, `tc`=0. Reset applies in the cycle it is sampled and overrides `load`/`en`.
- Reset mid-count: the next cycle shows `gray_out`=0 with no `tc` pulse. Counting resumes from 0 on the first `en` after `rst` deasserts.
- `load` and `en` high together: load wins and `tc`=0.
- Continuous `en` with `WRAP=1`: `tc` pulses once every 2^WIDTH cycles.

## Structure
- Shared package `gray_pkg`:
  - function `bin2gray(WIDTH)`
  - function `gray2bin(WIDTH)`, for bench reference models and downstream reuse
  - localparams for the `WRAP`/`SATURATE` mode encodings
- Sub-module `bin2gray_comb`:
  - purely combinational, parameterised on WIDTH
  - instantiated once to form the next `gray_out` from the next `cnt_q`
- The top level holds the count register, next-state mux, boundary detect, and the `tc` register.

## Test plan
All scenarios use WIDTH=4 unless noted.
- Reset: `rst`=1 for 2 cycles with `en`=1, `load`=1 → `gray_out`=0000, `tc`=0. Release `rst` and hold `en`=0 → outputs stay 0000.
- Up-count, `WRAP=1`: `en`=1, `up`=1 for 17 cycles from 0 → `gray_out` = 0000, 0001, 0011, 0010, 0110, … , 1000 (bin 15), then 0000 with `tc`=1 on that cycle only, then 0001. Every step changes exactly one bit.
- Down-count from 0, `WRAP=1`: `en`=1, `up`=0 → `gray_out`=1000 with `tc`=1, then 1001 (bin 14) with `tc`=0.
- Load priority: `load`=1, `load_val`=1010, `en`=1 in the same cycle → `gray_out`=1111, `tc`=0. Next cycle with `en`=1, `up`=1 → 1110 (bin 11).
- Saturate, `WRAP=0`: load 1111, then 3 cycles of `en`=1, `up`=1 → `gray_out` holds 1000 and `tc`=1 on all 3 cycles. Then `up`=0 → 1001, `tc`=0.
- Mid-count reset and width: count to bin 6 (0101), assert `rst` for 1 cycle → 0000, `tc`=0, and counting restarts at 0001. Repeat the 2^WIDTH wrap test with WIDTH=8 → `tc` period 256.
